riscv_dmem_rsp: RTL and testbench

Data-memory response stage, directly downstream of the load/store unit. Records every issued data access in a small in-order queue and matches each `dmem_ack` to its head entry. Aligns and sign-/zero-extends load data, raises memory exceptions, and presents one registered write-back result per completed access to the WB stage. Supports pipeline flush while accesses are still outstanding.

---
 rtl/riscv_dmem_rsp_pkg.sv | 39 +++
 rtl/riscv_dmem_rsp_fifo.sv | 72 +++++++
 rtl/riscv_dmem_rsp.sv | 151 +++++++++++++++
 tb/tb_riscv_dmem_rsp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_rsp_pkg.sv
// Shared types for the data-memory response stage: access sizes, exception causes, queue entry.
// Optional macro RISCV_DMEM_RSP_MISALIGN_CHK_EN adds a locally computed misalignment bit per entry.
package riscv_dmem_rsp_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } biu_size_t;

  localparam int EXCEPTION_SIZE         = 16;
  localparam int CAUSE_MISALIGNED_LOAD  = 4;
  localparam int CAUSE_MISALIGNED_STORE = 6;
  localparam int CAUSE_LOAD_PAGE_FAULT  = 13;
  localparam int CAUSE_STORE_PAGE_FAULT = 15;

  // One outstanding access; the per-entry kill bit lives beside it in the queue.
  typedef struct packed {
    logic       we;
    biu_size_t  size;
    logic [2:0] off;
    logic       ld_unsigned;
    logic [4:0] rd;
`ifdef RISCV_DMEM_RSP_MISALIGN_CHK_EN
    logic       mis;
`endif
  } dmem_entry_t;

  function automatic logic is_misaligned(biu_size_t size, logic [2:0] off);
    case (size)
      HWORD:   return off[0];
      WORD:    return |off[1:0];
      DWORD:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_dmem_rsp_fifo.sv
// In-order circular queue of outstanding accesses with a kill-all input that marks every valid entry.
// Push is ignored when full and pop is ignored when empty.
module riscv_dmem_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_kill_all,
  output logic [W-1:0]           o_head_data,
  output logic                   o_head_kill,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] w_valid;
  logic             w_push;
  logic             w_pop;

  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];
  assign o_head_kill = r_kill[r_rd_ptr];
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;

  // Slot i is occupied when its distance from the read pointer is below the count.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ((AW+1)'(AW'(AW'(i) - r_rd_ptr)) < r_count);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_kill   <= '0;
    end else begin
      if (i_kill_all) r_kill <= r_kill | w_valid;
      if (w_push) begin
        r_kill[r_wr_ptr] <= 1'b0;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_dmem_rsp.sv
// Data-memory response stage: queues issued accesses, aligns/extends load data, raises exceptions.
// Optional macro RISCV_DMEM_RSP_MISALIGN_CHK_EN enables the local misalignment check at issue.
module riscv_dmem_rsp
  import riscv_dmem_rsp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_dmem_req,
  input  logic                      i_dmem_we,
  input  biu_size_t                 i_dmem_size,
  input  logic [XLEN-1:0]           i_dmem_adr,
  input  logic                      i_ld_unsigned,
  input  logic [4:0]                i_ld_rd,
  output logic                      o_rsp_stall,
  input  logic                      i_dmem_ack,
  input  logic [XLEN-1:0]           i_dmem_q,
  input  logic                      i_dmem_misaligned,
  input  logic                      i_dmem_page_fault,
  output logic                      o_wb_valid,
  output logic                      o_wb_we,
  output logic [4:0]                o_wb_dst,
  output logic [XLEN-1:0]           o_wb_r,
  output logic [EXCEPTION_SIZE-1:0] o_wb_exception
);

  // Handshake: an access is accepted on i_dmem_req && !o_rsp_stall; i_dmem_ack retires the head
  // only when the queue is non-empty; o_wb_valid is a one-cycle pulse with no back-pressure.

  dmem_entry_t               w_push_entry;
  dmem_entry_t               w_head;
  logic                      w_head_kill;
  logic                      w_empty;
  logic [$clog2(DEPTH):0]    w_count;
  logic                      w_pop;
  logic                      w_kill;
  logic                      w_mis;
  logic [2:0]                w_off;
  logic [XLEN-1:0]           w_shift;
  logic [XLEN-1:0]           w_mask;
  logic                      w_sign;
  logic [XLEN-1:0]           w_load;
  logic [EXCEPTION_SIZE-1:0] w_exc;
  logic                      w_unused_adr;

  logic                      r_wb_valid;
  logic                      r_wb_we;
  logic [4:0]                r_wb_dst;
  logic [XLEN-1:0]           r_wb_r;
  logic [EXCEPTION_SIZE-1:0] r_wb_exception;

  assign w_unused_adr = ^{i_dmem_adr[XLEN-1:3], w_count};

  always_comb begin
    w_push_entry             = '0;
    w_push_entry.we          = i_dmem_we;
    w_push_entry.size        = i_dmem_size;
    w_push_entry.off         = i_dmem_adr[2:0];
    w_push_entry.ld_unsigned = i_ld_unsigned;
    w_push_entry.rd          = i_ld_rd;
`ifdef RISCV_DMEM_RSP_MISALIGN_CHK_EN
    w_push_entry.mis         = is_misaligned(i_dmem_size, i_dmem_adr[2:0]);
`endif
  end

  riscv_dmem_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(dmem_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (i_dmem_req),
    .i_push_data (w_push_entry),
    .i_pop       (i_dmem_ack),
    .i_kill_all  (i_flush),
    .o_head_data (w_head),
    .o_head_kill (w_head_kill),
    .o_count     (w_count),
    .o_full      (o_rsp_stall),
    .o_empty     (w_empty)
  );

  assign w_pop  = i_dmem_ack && !w_empty;
  assign w_kill = w_head_kill || i_flush;

  // A 32-bit datapath only sees the byte lane within its word.
  assign w_off   = (XLEN == 32) ? {1'b0, w_head.off[1:0]} : w_head.off;
  assign w_shift = i_dmem_q >> {w_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (w_head.size)
      BYTE:    begin w_mask = XLEN'(8'hFF);         w_sign = w_shift[7];  end
      HWORD:   begin w_mask = XLEN'(16'hFFFF);      w_sign = w_shift[15]; end
      WORD:    begin w_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
      default: begin w_mask = '1;                   w_sign = 1'b0;        end
    endcase
  end

  assign w_load = (w_head.size == DWORD) ? i_dmem_q :
                  ((w_shift & w_mask) | ((w_sign && !w_head.ld_unsigned) ? ~w_mask : '0));

`ifdef RISCV_DMEM_RSP_MISALIGN_CHK_EN
  assign w_mis = i_dmem_misaligned || w_head.mis;
`else
  assign w_mis = i_dmem_misaligned;
`endif

  always_comb begin
    w_exc = '0;
    if (w_mis) begin
      w_exc[w_head.we ? CAUSE_MISALIGNED_STORE : CAUSE_MISALIGNED_LOAD] = 1'b1;
    end else if (i_dmem_page_fault) begin
      w_exc[w_head.we ? CAUSE_STORE_PAGE_FAULT : CAUSE_LOAD_PAGE_FAULT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_wb_dst       <= '0;
      r_wb_r         <= '0;
      r_wb_exception <= '0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_wb_dst       <= '0;
      r_wb_r         <= '0;
      r_wb_exception <= '0;
      if (w_pop && !w_kill) begin
        r_wb_valid     <= 1'b1;
        r_wb_we        <= !w_head.we && (w_exc == '0);
        r_wb_dst       <= w_head.rd;
        r_wb_r         <= w_head.we ? '0 : w_load;
        r_wb_exception <= w_exc;
      end
    end
  end

  assign o_wb_valid     = r_wb_valid;
  assign o_wb_we        = r_wb_we;
  assign o_wb_dst       = r_wb_dst;
  assign o_wb_r         = r_wb_r;
  assign o_wb_exception = r_wb_exception;

endmodule

// File: tb/tb_riscv_dmem_rsp.sv
// Bench for riscv_dmem_rsp: XLEN=32 and XLEN=64 instances share stimulus and are checked against
// a queue-based reference model; directed steps first, then random traffic.
module tb_riscv_dmem_rsp;
  import riscv_dmem_rsp_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        req;
  logic        we;
  biu_size_t   size;
  logic [63:0] adr;
  logic        uns;
  logic [4:0]  rd;
  logic        ack;
  logic [63:0] q;
  logic        dm_mis;
  logic        pf;

  logic        stall32, v32, we32;
  logic [4:0]  dst32;
  logic [31:0] r32;
  logic [15:0] exc32;
  logic        stall64, v64, we64;
  logic [4:0]  dst64;
  logic [63:0] r64;
  logic [15:0] exc64;

  riscv_dmem_rsp #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_dmem_req(req), .i_dmem_we(we),
    .i_dmem_size(size), .i_dmem_adr(adr[31:0]), .i_ld_unsigned(uns), .i_ld_rd(rd),
    .o_rsp_stall(stall32), .i_dmem_ack(ack), .i_dmem_q(q[31:0]),
    .i_dmem_misaligned(dm_mis), .i_dmem_page_fault(pf), .o_wb_valid(v32), .o_wb_we(we32),
    .o_wb_dst(dst32), .o_wb_r(r32), .o_wb_exception(exc32)
  );

  riscv_dmem_rsp #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_dmem_req(req), .i_dmem_we(we),
    .i_dmem_size(size), .i_dmem_adr(adr), .i_ld_unsigned(uns), .i_ld_rd(rd),
    .o_rsp_stall(stall64), .i_dmem_ack(ack), .i_dmem_q(q),
    .i_dmem_misaligned(dm_mis), .i_dmem_page_fault(pf), .o_wb_valid(v64), .o_wb_we(we64),
    .o_wb_dst(dst64), .o_wb_r(r64), .o_wb_exception(exc64)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    bit         we;
    int         sz;
    int         off;
    bit         u;
    logic [4:0] rd;
    bit         kill;
    bit         lmis;
  } m_entry_t;

  m_entry_t    exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        e_valid, e_we, e_full;
  logic [4:0]  e_dst;
  logic [63:0] e_r32, e_r64;
  logic [15:0] e_exc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int xlen, input int sz, input int off,
                                             input bit u, input logic [63:0] raw);
    logic [63:0] data, v, m;
    int nb, sh;
    data = (xlen == 32) ? {32'h0, raw[31:0]} : raw;
    if (sz == 3) return data;
    sh = (xlen == 32) ? off % 4 : off;
    v  = data >> (8 * sh);
    nb = 8 << sz;
    if (nb >= xlen) return v;
    m = (64'd1 << nb) - 64'd1;
    v = v & m;
    if (!u && v[nb-1]) v = v | ~m;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic model_step();
    m_entry_t m;
    bit       full_now;
    bit       mis;
    e_valid = 0; e_we = 0; e_dst = '0; e_r32 = '0; e_r64 = '0; e_exc = '0; e_full = 0;
    if (rst) begin
      exp_q.delete();
      e_full = 1;
      return;
    end
    full_now = (exp_q.size() == DEPTH);
    if (ack && exp_q.size() != 0) begin
      m = exp_q.pop_front();
      if (!(m.kill || flush)) begin
        e_valid = 1;
        mis = dm_mis || m.lmis;
        if (mis)     e_exc = 16'(1 << (m.we ? 6 : 4));
        else if (pf) e_exc = 16'(1 << (m.we ? 15 : 13));
        e_we  = !m.we && (e_exc == 0);
        e_dst = m.rd;
        e_r32 = m.we ? 64'h0 : model_load(32, m.sz, m.off, m.u, q);
        e_r64 = m.we ? 64'h0 : model_load(64, m.sz, m.off, m.u, q);
      end
    end
    if (flush) foreach (exp_q[i]) exp_q[i].kill = 1;
    if (req && !full_now) begin
      m.we   = we;
      m.sz   = int'(size);
      m.off  = int'(adr[2:0]);
      m.u    = uns;
      m.rd   = rd;
      m.kill = 0;
`ifdef RISCV_DMEM_RSP_MISALIGN_CHK_EN
      m.lmis = (m.off % (1 << m.sz)) != 0;
`else
      m.lmis = 0;
`endif
      exp_q.push_back(m);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rst = 0; flush = 0; req = 0; we = 0; ack = 0; dm_mis = 0; pf = 0;
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input logic [63:0] a,
                       input bit u, input logic [4:0] r);
    req = 1; we = w; size = biu_size_t'(sz); adr = a; uns = u; rd = r;
  endtask

  task automatic do_ack(input logic [63:0] d, input bit m, input bit p);
    ack = 1; q = d; dm_mis = m; pf = p;
  endtask

  // One clock: check stall before the edge, advance model, compare registered outputs after it.
  task automatic tick();
    check("stall32", {63'h0, stall32}, {63'h0, exp_q.size() == DEPTH});
    check("stall64", {63'h0, stall64}, {63'h0, exp_q.size() == DEPTH});
    @(posedge clk);
    model_step();
    #1;
    check("valid32", {63'h0, v32}, {63'h0, e_valid});
    check("valid64", {63'h0, v64}, {63'h0, e_valid});
    if (e_valid || e_full) begin
      check("we32",  {63'h0, we32},  {63'h0, e_we});
      check("we64",  {63'h0, we64},  {63'h0, e_we});
      check("dst32", {59'h0, dst32}, {59'h0, e_dst});
      check("dst64", {59'h0, dst64}, {59'h0, e_dst});
      check("exc32", {48'h0, exc32}, {48'h0, e_exc});
      check("exc64", {48'h0, exc64}, {48'h0, e_exc});
      if (e_exc == 0) begin
        check("r32", {32'h0, r32}, e_r32);
        check("r64", r64, e_r64);
      end
    end
    clear_inputs();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    clear_inputs();
    size = BYTE; adr = '0; uns = 0; rd = '0; q = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid32", {63'h0, v32}, 64'h0);
    check("rst_valid64", {63'h0, v64}, 64'h0);
    check("rst_we32",    {63'h0, we32}, 64'h0);
    check("rst_dst64",   {59'h0, dst64}, 64'h0);
    check("rst_r32",     {32'h0, r32}, 64'h0);
    check("rst_r64",     r64, 64'h0);
    check("rst_exc64",   {48'h0, exc64}, 64'h0);
    check("rst_stall32", {63'h0, stall32}, 64'h0);
    rst = 0;

    // LB / LBU at offset 3
    issue(0, 2'd0, 64'h3, 0, 5'd5); tick();
    do_ack(64'h80FF_1234, 0, 0);    tick();
    check("lb32_r", {32'h0, r32}, 64'hFFFF_FF80);
    check("lb32_we", {63'h0, we32}, 64'h1);
    issue(0, 2'd0, 64'h3, 1, 5'd6); tick();
    do_ack(64'h80FF_1234, 0, 0);    tick();
    check("lbu32_r", {32'h0, r32}, 64'h0000_0080);

    // LWU / LW at offset 4
    issue(0, 2'd2, 64'h4, 1, 5'd7); tick();
    do_ack(64'hDEAD_BEEF_0000_0001, 0, 0); tick();
    check("lwu64_r", r64, 64'h0000_0000_DEAD_BEEF);
    issue(0, 2'd2, 64'h4, 0, 5'd8); tick();
    do_ack(64'hDEAD_BEEF_0000_0001, 0, 0); tick();
    check("lw64_r", r64, 64'hFFFF_FFFF_DEAD_BEEF);

    // Fill queue, drop third request, drain in order, ack on empty
    issue(0, 2'd2, 64'h0, 0, 5'd1); tick();
    issue(0, 2'd2, 64'h0, 0, 5'd2); tick();
    check("full_stall32", {63'h0, stall32}, 64'h1);
    issue(0, 2'd2, 64'h0, 0, 5'd3); tick();
    do_ack(64'h1111_2222_3333_4444, 0, 0); tick();
    check("order_dst1", {59'h0, dst32}, 64'd1);
    do_ack(64'h5555_6666_7777_8888, 0, 0); tick();
    check("order_dst2", {59'h0, dst64}, 64'd2);
    do_ack(64'h0, 0, 0); tick();

    // Flush of two queued loads
    issue(0, 2'd1, 64'h0, 0, 5'd10); tick();
    issue(0, 2'd1, 64'h2, 0, 5'd11); tick();
    flush = 1; tick();
    do_ack(64'hAAAA_BBBB, 0, 0); tick();
    do_ack(64'hCCCC_DDDD, 0, 0); tick();
    // Push in the flush cycle survives
    issue(0, 2'd0, 64'h1, 0, 5'd12); tick();
    issue(0, 2'd0, 64'h2, 1, 5'd13); flush = 1; tick();
    do_ack(64'h0012_3456, 0, 0); tick();
    do_ack(64'h0012_3456, 0, 0); tick();
    check("flush_push_valid", {63'h0, v32}, 64'h1);
    check("flush_push_dst",   {59'h0, dst32}, 64'd13);

    // SH at offset 1 with memory reporting aligned
    issue(1, 2'd1, 64'h1, 0, 5'd0); tick();
    do_ack(64'h0, 0, 0); tick();
`ifdef RISCV_DMEM_RSP_MISALIGN_CHK_EN
    check("sh_mis_exc", {48'h0, exc32}, 64'h0040);
`else
    check("sh_mis_exc", {48'h0, exc32}, 64'h0000);
`endif

    // LW with page fault, then memory-side misalign overriding page fault on a store
    issue(0, 2'd2, 64'h0, 0, 5'd14); tick();
    do_ack(64'h1234_5678, 0, 1); tick();
    check("lw_pf_exc", {48'h0, exc64}, 64'h2000);
    check("lw_pf_we",  {63'h0, we64}, 64'h0);
    issue(1, 2'd2, 64'h0, 0, 5'd15); tick();
    do_ack(64'h0, 1, 1); tick();
    check("sw_mis_exc", {48'h0, exc32}, 64'h0040);

    // Reset with one entry queued, then ack
    issue(0, 2'd2, 64'h0, 0, 5'd16); tick();
    rst = 1; tick();
    do_ack(64'hFFFF_FFFF, 0, 0); tick();
    check("rst_ack_valid", {63'h0, v64}, 64'h0);

    // Push and ack in the same cycle on an empty queue
    issue(0, 2'd0, 64'h0, 0, 5'd17); do_ack(64'h0, 0, 0); tick();
    do_ack(64'h7F, 0, 0); tick();
    check("same_cycle_dst", {59'h0, dst32}, 64'd17);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1)
        do_ack({$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
